// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB requester bridge.
//   apb_state_t : bridge FSM encoding (IDLE -> SETUP -> ACCESS -> RESP)
//   apb_cmd_t   : one command as accepted on the valid/ready command channel,
//                 sized with the default widths
package apb_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned WAIT_W_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // 'wait' is a keyword, hence wait_st
    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [WAIT_W_DEF-1:0] wait_st;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns one valid/ready command into one APB SETUP->ACCESS
// transfer and returns the result on a valid/ready response channel.
// Single outstanding transfer. A watchdog aborts ACCESS after TIMEOUT cycles
// without PREADY (TIMEOUT=0 disables it).
// Ports:
//   PCLK, PRESET              clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_ready = (state == IDLE)
//   cmd_write/addr/wdata/wait command payload, latched on the handshake
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        read data (0 for writes/aborts), abort flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PWAIT   APB request to the slave
//   PREADY, PRDATA            APB completion from the slave
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned WAIT_W  = WAIT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [WAIT_W-1:0] cmd_wait,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [WAIT_W-1:0] PWAIT,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    // Counter keeps at least one bit so a disabled watchdog still elaborates.
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [WAIT_W-1:0] pwait_q,     pwait_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WD_W-1:0]   wd_cnt_q,    wd_cnt_d;

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwait_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwait_q     <= pwait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwait_d     = pwait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wd_cnt_d    = wd_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwait_d   = cmd_wait;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wd_cnt_d  = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over the watchdog on the final allowed cycle.
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWAIT     = pwait_q;

endmodule
